// File: rtl/fa_response_checker.sv
// ---------------------------------------------------------------------------
// fa_response_checker
//
// Checks the observed sum (smp_f1) and carry (smp_f2) outputs of a full-adder
// under test against the expected values for the applied stimulus smp_abc.
// A session starts on a start pulse. It counts matching and mismatching
// samples and records which of the eight input vectors have been seen. The
// session ends when every vector has been checked or when the cycle budget
// runs out.
//
// Parameters
//   CNT_W    width of the saturating pass/fail counters
//   TIMEOUT  maximum number of RUN cycles before the session is forced to end
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      one-cycle pulse; begins a session from IDLE or DONE
//   smp_valid  smp_* carries a sample this cycle
//   smp_abc    applied stimulus: bit2=A, bit1=B, bit0=C
//   smp_f1     observed sum output
//   smp_f2     observed carry output
//   busy       high while a session is running
//   done       high once a session has finished
//   pass       verdict; 1 only in DONE with zero failures and full coverage
//   pass_cnt   saturating count of matching samples
//   fail_cnt   saturating count of mismatching samples
//   cov_mask   bit n set once a sample with smp_abc==n has been checked
//   timed_out  the session ended by timeout rather than by full coverage
//
// Optional feature (macro FIRST_FAIL_CAPTURE_EN)
//   ff_valid   a mismatch has been captured in this session
//   ff_abc     smp_abc of the first mismatch in this session
// ---------------------------------------------------------------------------
module fa_response_checker #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             smp_valid,
    input  logic [2:0]       smp_abc,
    input  logic             smp_f1,
    input  logic             smp_f2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [7:0]       cov_mask,
    output logic             timed_out
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic             ff_valid,
    output logic [2:0]       ff_abc
`endif
);

    localparam int CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [7:0]         r_cov_mask;
    logic               r_timed_out;
    logic [CYC_W-1:0]   r_cyc;

    logic               w_exp_f1;
    logic               w_exp_f2;
    logic               w_match;
    logic               w_count;
    logic               w_enter_run;
    logic [7:0]         w_cov_nxt;
    logic               w_cov_full;
    logic               w_timeout;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        w_exp_f1    = smp_abc[2] ^ smp_abc[1] ^ smp_abc[0];
        w_exp_f2    = (smp_abc[2] & smp_abc[1]) | (smp_abc[2] & smp_abc[0]) |
                      (smp_abc[1] & smp_abc[0]);
        w_match     = (smp_f1 == w_exp_f1) && (smp_f2 == w_exp_f2);
        w_count     = (r_state == S_RUN) && smp_valid;
        // Coverage including the sample of this cycle, so the session can
        // end on the edge that records the last missing vector.
        w_cov_nxt   = r_cov_mask | (w_count ? (8'd1 << smp_abc) : 8'd0);
        w_cov_full  = (w_cov_nxt == 8'hFF);
        w_timeout   = (r_cyc == CYC_W'(TIMEOUT - 1));
        // start is only honoured outside RUN; a sample arriving with it is
        // dropped because w_count is low outside RUN.
        w_enter_run = start && (r_state != S_RUN);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_cov_full || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || w_enter_run) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_cov_mask  <= '0;
            r_timed_out <= 1'b0;
            r_cyc       <= '0;
        end else if (r_state == S_RUN) begin
            if (w_count) begin
                if (w_match) r_pass_cnt <= sat_inc(r_pass_cnt);
                else         r_fail_cnt <= sat_inc(r_fail_cnt);
                r_cov_mask <= w_cov_nxt;
            end
            // Full coverage wins over a coincident timeout.
            if (w_timeout && !w_cov_full) r_timed_out <= 1'b1;
            if (w_state_nxt == S_RUN)     r_cyc <= r_cyc + CYC_W'(1);
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    logic       r_ff_valid;
    logic [2:0] r_ff_abc;

    always_ff @(posedge clk) begin
        if (rst || w_enter_run) begin
            r_ff_valid <= 1'b0;
            r_ff_abc   <= '0;
        end else if (w_count && !w_match && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_abc   <= smp_abc;
        end
    end

    assign ff_valid = r_ff_valid;
    assign ff_abc   = r_ff_abc;
`endif

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign pass      = (r_state == S_DONE) && (r_fail_cnt == '0) && (r_cov_mask == 8'hFF);
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign cov_mask  = r_cov_mask;
    assign timed_out = r_timed_out;

endmodule
